// File: rtl/pcileech_tlps128_elastic_buffer.sv
// Packet-aware 128-bit TLP elastic FIFO. It absorbs tvalid gaps and
// backpressure from the upstream jitter stage. It can optionally hold each
// packet until its tlast beat is stored (store-and-forward), and it reports
// current and peak occupancy.
`timescale 1ns/1ps
module pcileech_tlps128_elastic_buffer #(
    parameter int  DEPTH     = 16,
    parameter bit  STORE_FWD = 1'b1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          clk_pcie,
    input  logic          rst,
    // upstream beats
    input  logic [127:0]  tlps_in_tdata,
    input  logic [3:0]    tlps_in_tkeepdw,
    input  logic          tlps_in_tvalid,
    output logic          tlps_in_tready,
    input  logic          tlps_in_tlast,
    input  logic [8:0]    tlps_in_tuser,
    input  logic          tlps_in_has_data,
    // buffered beats to the consumer
    output logic [127:0]  tlps_out_tdata,
    output logic [3:0]    tlps_out_tkeepdw,
    output logic          tlps_out_tvalid,
    input  logic          tlps_out_tready,
    output logic          tlps_out_tlast,
    output logic [8:0]    tlps_out_tuser,
    output logic          tlps_out_has_data,
    // debug status
    output logic [AW:0]   level,
    output logic [AW:0]   level_hwm
);

    localparam int          EW  = 142;
    localparam logic [AW:0] ONE = (AW + 1)'(1);

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   pkt_cnt;
    logic [AW:0]   level_next;
    logic          gate_open;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          push_last;
    logic          pop_last;
    logic          unused_has_data;

    // Upstream has_data is informational only; the buffer derives its own.
    assign unused_has_data = tlps_in_has_data;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // Ready depends only on registered pointers, so a same-cycle pop never
    // reopens a full buffer.
    assign tlps_in_tready = !full && !rst;

    // In store-and-forward mode a stored tlast means the head packet is
    // complete, so once its first beat leaves, the rest follows without a
    // gap. gate_open relieves packets longer than the buffer.
    assign tlps_out_tvalid = !empty && (!STORE_FWD || (pkt_cnt != '0) || gate_open);

    assign push      = tlps_in_tvalid && tlps_in_tready;
    assign pop       = tlps_out_tvalid && tlps_out_tready;
    assign push_last = push && tlps_in_tlast;
    assign pop_last  = pop && tlps_out_tlast;

    // First-word fall-through read of the head entry.
    assign head = mem[rd_ptr[AW-1:0]];
    assign {tlps_out_tuser, tlps_out_tlast, tlps_out_tkeepdw, tlps_out_tdata} = head;

    assign tlps_out_has_data = (pkt_cnt != '0) || !empty;

    assign level      = wr_ptr - rd_ptr;
    assign level_next = level + (push ? ONE : '0) - (pop ? ONE : '0);

    // Beat storage; contents need no reset because pointers define validity.
    always_ff @(posedge clk_pcie) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {tlps_in_tuser, tlps_in_tlast, tlps_in_tkeepdw, tlps_in_tdata};
        end
    end

    // Write/read pointers with wrap bit.
    always_ff @(posedge clk_pcie or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE;
            if (pop)  rd_ptr <= rd_ptr + ONE;
        end
    end

    // Count of complete packets currently held.
    always_ff @(posedge clk_pcie or posedge rst) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else begin
            case ({push_last, pop_last})
                2'b10:   pkt_cnt <= pkt_cnt + ONE;
                2'b01:   pkt_cnt <= pkt_cnt - ONE;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    // Oversize-packet relief: open when full with no complete packet, close at tlast.
    always_ff @(posedge clk_pcie or posedge rst) begin
        if (rst) begin
            gate_open <= 1'b0;
        end else if (pop_last) begin
            gate_open <= 1'b0;
        end else if (full && (pkt_cnt == '0)) begin
            gate_open <= 1'b1;
        end
    end

    // Peak occupancy since reset.
    always_ff @(posedge clk_pcie or posedge rst) begin
        if (rst) begin
            level_hwm <= '0;
        end else if (level_next > level_hwm) begin
            level_hwm <= level_next;
        end
    end

endmodule

// File: tb/tb_pcileech_tlps128_elastic_buffer.sv
// Self-checking bench for pcileech_tlps128_elastic_buffer: one cut-through
// and one store-and-forward instance, compared against a queue-based model.
`timescale 1ns/1ps
module tb_pcileech_tlps128_elastic_buffer;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef struct packed {
        logic [8:0]   user;
        logic         last;
        logic [3:0]   keep;
        logic [127:0] data;
    } beat_t;

    logic  clk_pcie   = 1'b0;
    logic  rst        = 1'b1;
    logic  sel        = 1'b0;   // 0: cut-through instance, 1: store-and-forward
    logic  in_tvalid  = 1'b0;
    beat_t in_beat    = '0;
    logic  out_tready = 1'b0;

    logic          ct_in_tready, ct_out_tvalid, ct_out_tlast, ct_out_has_data;
    logic [127:0]  ct_out_tdata;
    logic [3:0]    ct_out_tkeepdw;
    logic [8:0]    ct_out_tuser;
    logic [AW:0]   ct_level, ct_hwm;
    logic          sf_in_tready, sf_out_tvalid, sf_out_tlast, sf_out_has_data;
    logic [127:0]  sf_out_tdata;
    logic [3:0]    sf_out_tkeepdw;
    logic [8:0]    sf_out_tuser;
    logic [AW:0]   sf_level, sf_hwm;

    logic          obs_rdy, obs_vld, obs_hd;
    logic [141:0]  obs_beat;
    logic [AW:0]   obs_level, obs_hwm;

    int ncmp  = 0;
    int nfail = 0;

    // model state
    beat_t q[$];
    bit    gate = 1'b0;
    int    hwm  = 0;

    always #5 clk_pcie = ~clk_pcie;

    pcileech_tlps128_elastic_buffer #(.DEPTH(DEPTH), .STORE_FWD(1'b0)) dut_ct (
        .clk_pcie(clk_pcie), .rst(rst),
        .tlps_in_tdata(in_beat.data), .tlps_in_tkeepdw(in_beat.keep),
        .tlps_in_tvalid(in_tvalid && !sel), .tlps_in_tready(ct_in_tready),
        .tlps_in_tlast(in_beat.last), .tlps_in_tuser(in_beat.user),
        .tlps_in_has_data(in_tvalid),
        .tlps_out_tdata(ct_out_tdata), .tlps_out_tkeepdw(ct_out_tkeepdw),
        .tlps_out_tvalid(ct_out_tvalid), .tlps_out_tready(out_tready && !sel),
        .tlps_out_tlast(ct_out_tlast), .tlps_out_tuser(ct_out_tuser),
        .tlps_out_has_data(ct_out_has_data),
        .level(ct_level), .level_hwm(ct_hwm)
    );

    pcileech_tlps128_elastic_buffer #(.DEPTH(DEPTH), .STORE_FWD(1'b1)) dut_sf (
        .clk_pcie(clk_pcie), .rst(rst),
        .tlps_in_tdata(in_beat.data), .tlps_in_tkeepdw(in_beat.keep),
        .tlps_in_tvalid(in_tvalid && sel), .tlps_in_tready(sf_in_tready),
        .tlps_in_tlast(in_beat.last), .tlps_in_tuser(in_beat.user),
        .tlps_in_has_data(in_tvalid),
        .tlps_out_tdata(sf_out_tdata), .tlps_out_tkeepdw(sf_out_tkeepdw),
        .tlps_out_tvalid(sf_out_tvalid), .tlps_out_tready(out_tready && sel),
        .tlps_out_tlast(sf_out_tlast), .tlps_out_tuser(sf_out_tuser),
        .tlps_out_has_data(sf_out_has_data),
        .level(sf_level), .level_hwm(sf_hwm)
    );

    assign obs_rdy   = sel ? sf_in_tready    : ct_in_tready;
    assign obs_vld   = sel ? sf_out_tvalid   : ct_out_tvalid;
    assign obs_hd    = sel ? sf_out_has_data : ct_out_has_data;
    assign obs_level = sel ? sf_level        : ct_level;
    assign obs_hwm   = sel ? sf_hwm          : ct_hwm;
    assign obs_beat  = sel ? {sf_out_tuser, sf_out_tlast, sf_out_tkeepdw, sf_out_tdata}
                           : {ct_out_tuser, ct_out_tlast, ct_out_tkeepdw, ct_out_tdata};

    task automatic chk(input string tag, input logic [141:0] obs, input logic [141:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk(input logic [127:0] d, input logic l);
        beat_t r;
        r.data = d;
        r.last = l;
        r.keep = 4'($urandom);
        r.user = 9'($urandom);
        return r;
    endfunction

    // One clock cycle: drive, check outputs against the model, then advance the model.
    task automatic step(input logic tv, input beat_t b, input logic otr, output bit pushed);
        int cmpl;
        bit exp_rdy, exp_vld, pop;
        @(negedge clk_pcie);
        in_tvalid  = tv;
        in_beat    = b;
        out_tready = otr;
        #1;
        cmpl = 0;
        foreach (q[i]) if (q[i].last) cmpl++;
        exp_rdy = (q.size() < DEPTH);
        exp_vld = (q.size() > 0) && (!sel || cmpl > 0 || gate);
        chk("in_tready", 142'(obs_rdy), 142'(exp_rdy));
        chk("out_tvalid", 142'(obs_vld), 142'(exp_vld));
        if (exp_vld) chk("out_beat", obs_beat, q[0]);
        chk("level", 142'(obs_level), 142'(q.size()));
        chk("level_hwm", 142'(obs_hwm), 142'(hwm));
        chk("has_data", 142'(obs_hd), 142'(q.size() > 0));
        pushed = tv && exp_rdy;
        pop    = exp_vld && otr;
        @(posedge clk_pcie);
        if (pop && q[0].last) gate = 1'b0;
        else if (q.size() == DEPTH && cmpl == 0) gate = 1'b1;
        if (pop) void'(q.pop_front());
        if (pushed) q.push_back(b);
        if (q.size() > hwm) hwm = q.size();
    endtask

    // Offer one beat until accepted, with optional idle gaps and random consumer stalls.
    task automatic send_beat(input beat_t b, input int gap_pct, input int otr_pct);
        bit   p;
        int   n;
        logic otr;
        p = 1'b0;
        n = 0;
        while (!p && n < 64) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                otr = ($urandom_range(0, 99) < otr_pct);
                step(1'b0, b, otr, p);
            end
            otr = ($urandom_range(0, 99) < otr_pct);
            step(1'b1, b, otr, p);
            n++;
        end
        chk("send_accept", 142'(p), 142'(1));
    endtask

    task automatic drain(input int maxc);
        bit p;
        int n;
        n = 0;
        while (q.size() > 0 && n < maxc) begin
            step(1'b0, '0, 1'b1, p);
            n++;
        end
        step(1'b0, '0, 1'b1, p);
        @(negedge clk_pcie);
        #1;
        chk("drain_level", 142'(obs_level), 142'(0));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic reset_mid(input logic s);
        @(negedge clk_pcie);
        in_tvalid  = 1'b0;
        out_tready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_tready", 142'(obs_rdy), 142'(0));
        chk("rst_tvalid", 142'(obs_vld), 142'(0));
        chk("rst_has_data", 142'(obs_hd), 142'(0));
        chk("rst_level", 142'(obs_level), 142'(0));
        chk("rst_hwm", 142'(obs_hwm), 142'(0));
        q.delete();
        gate = 1'b0;
        hwm  = 0;
        @(negedge clk_pcie);
        sel = s;
        @(negedge clk_pcie);
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit p;
        int len;

        #3;
        chk("init_tready", 142'(obs_rdy), 142'(0));
        chk("init_tvalid", 142'(obs_vld), 142'(0));
        chk("init_level", 142'(obs_level), 142'(0));
        reset_mid(1'b0);

        // cut-through, 4-beat packet tdata 1..4, consumer always ready
        for (int i = 1; i <= 4; i++) send_beat(mk(128'(i), i == 4), 0, 100);
        drain(10);
        chk("ct_hwm", 142'(obs_hwm), 142'(1));

        // fill with consumer stalled: 20 offered, 16 accepted
        reset_mid(1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, mk(128'(i + 100), (i % 4) == 3), 1'b0, p);
        @(negedge clk_pcie);
        #1;
        chk("fill_level", 142'(obs_level), 142'(16));
        chk("fill_hwm", 142'(obs_hwm), 142'(16));
        chk("fill_tready", 142'(obs_rdy), 142'(0));
        drain(40);

        // store-and-forward, 3 beats with single-cycle input gaps
        reset_mid(1'b1);
        step(1'b1, mk(128'(1), 1'b0), 1'b1, p);
        step(1'b0, '0, 1'b1, p);
        step(1'b1, mk(128'(2), 1'b0), 1'b1, p);
        step(1'b0, '0, 1'b1, p);
        step(1'b1, mk(128'(3), 1'b1), 1'b1, p);
        drain(10);

        // oversize 20-beat packet must not deadlock
        for (int i = 0; i < 20; i++) send_beat(mk(128'(i + 200), i == 19), 0, 100);
        drain(40);
        chk("os_gate_closed", 142'(dut_sf.gate_open), 142'(0));

        // random packets, store-and-forward, across pointer wrap
        reset_mid(1'b1);
        for (int k = 0; k < 100; k++) begin
            len = $urandom_range(1, 8);
            for (int b = 0; b < len; b++)
                send_beat(mk({$urandom, $urandom, $urandom, $urandom}, b == len - 1), 25, 70);
        end
        drain(100);
        chk("sf_pkt_cnt_end", 142'(dut_sf.pkt_cnt), 142'(0));
        chk("sf_has_data_end", 142'(obs_hd), 142'(0));

        // random packets, cut-through
        reset_mid(1'b0);
        for (int k = 0; k < 30; k++) begin
            len = $urandom_range(1, 8);
            for (int b = 0; b < len; b++)
                send_beat(mk({$urandom, $urandom, $urandom, $urandom}, b == len - 1), 25, 60);
        end
        drain(100);
        chk("ct_pkt_cnt_end", 142'(dut_ct.pkt_cnt), 142'(0));

        // reset after 2 of 5 beats, then a fresh 2-beat packet must emerge alone
        reset_mid(1'b1);
        send_beat(mk(128'h51, 1'b0), 0, 100);
        send_beat(mk(128'h52, 1'b0), 0, 100);
        reset_mid(1'b1);
        send_beat(mk(128'h61, 1'b0), 0, 100);
        send_beat(mk(128'h62, 1'b1), 0, 100);
        drain(10);
        chk("post_rst_hwm", 142'(obs_hwm), 142'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
